// File: rtl/melody_sequencer_if.sv
// Melody memory read port: req/valid handshake, one byte per completed transfer.
interface melody_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [7:0]        mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_valid,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_valid,
    output mem_data
  );
endinterface

// File: rtl/melody_sequencer.sv
// Byte-coded melody player: fetches events from melody memory and drives the two
// channel note registers, timing delays with a tick prescaler.
module melody_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h10,
  parameter int                TICK_DIV   = 25000
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  melody_sequencer_if.master       mem,
  output logic [5:0]               note1,
  output logic [5:0]               note2,
  output logic                     busy,
  output logic                     done
);

  // TICK_DIV=1 would give a zero-width prescaler; keep one bit that stays at zero.
  localparam int                  PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LOAD = PRESC_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                rd_r, rd_s;
  logic [5:0]          note1_r, note1_s;
  logic [5:0]          note2_r, note2_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;
  logic [6:0]          dcnt_r, dcnt_s;
  logic [PRESC_W-1:0]  presc_r, presc_s;
  logic                xfer_s;

  // Next-state, event decode and delay timer update
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    note1_s = note1_r;
    note2_s = note2_r;
    done_s  = 1'b0;
    dcnt_s  = dcnt_r;
    presc_s = presc_r;
    xfer_s  = rd_r & mem.mem_valid;

    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          addr_s  = START_ADDR;
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end

      FETCH: begin
        if (stop) begin
          state_s = IDLE;
          note1_s = 6'd0;
          note2_s = 6'd0;
        end else if (xfer_s) begin
          if (mem.mem_data[7] == 1'b0) begin
            if (mem.mem_data[6] == 1'b0) begin
              note1_s = mem.mem_data[5:0];
            end else begin
              note2_s = mem.mem_data[5:0];
            end
            addr_s = addr_r + ADDR_ONE;
          end else if (mem.mem_data == 8'h80) begin
            addr_s = addr_r + ADDR_ONE;
          end else if (mem.mem_data != 8'hFF) begin
            // Low seven bits of 8'h81..8'hFE are exactly the tick count 1..126.
            dcnt_s  = mem.mem_data[6:0];
            presc_s = PRESC_LOAD;
            addr_s  = addr_r + ADDR_ONE;
            state_s = WAIT;
          end else if (loop_en && (addr_r != START_ADDR)) begin
            addr_s = START_ADDR;
          end else begin
            note1_s = 6'd0;
            note2_s = 6'd0;
            done_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = FETCH;
        end
      end

      WAIT: begin
        if (stop) begin
          state_s = IDLE;
          note1_s = 6'd0;
          note2_s = 6'd0;
        end else if (presc_r == {PRESC_W{1'b0}}) begin
          presc_s = PRESC_LOAD;
          dcnt_s  = dcnt_r - 7'd1;
          if (dcnt_r == 7'd1) begin
            state_s = FETCH;
          end else begin
            state_s = WAIT;
          end
        end else begin
          presc_s = presc_r - PRESC_W'(1);
        end
      end

      default: begin
        state_s = IDLE;
        note1_s = 6'd0;
        note2_s = 6'd0;
      end
    endcase

    rd_s   = (state_s == FETCH);
    busy_s = (state_s != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      rd_r    <= 1'b0;
      note1_r <= 6'd0;
      note2_r <= 6'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      dcnt_r  <= 7'd0;
      presc_r <= {PRESC_W{1'b0}};
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      rd_r    <= rd_s;
      note1_r <= note1_s;
      note2_r <= note2_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      dcnt_r  <= dcnt_s;
      presc_r <= presc_s;
    end
  end

  assign mem.mem_rd   = rd_r;
  assign mem.mem_addr = addr_r;
  assign note1        = note1_r;
  assign note2        = note2_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Hardware event sequencer that plays a byte-coded melody stream into the two note_sine_gen channels, replacing the software loop on ok8cpu for playback.
- Fetches event bytes from a byte memory over a req/valid read handshake and decodes each byte as a channel-1 note, a channel-2 note, a delay, or end-of-melody.
- Holds the two 6-bit channel note registers and times delays with an internal tick prescaler.
- Sits between melody storage and the channel note inputs in the top level.

Parameters:
- ADDR_W, 8: width of the melody memory address.
- START_ADDR, 8'h10: address of the first melody event; reload point for looping.
- TICK_DIV, 25000: clk cycles per delay tick (1 to 2^20).

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin playback from START_ADDR.
- stop  input  1  single-cycle request to abort playback.
- loop_en  input  1  sampled at end-of-melody; 1 means restart from START_ADDR.
- mem_rd  output  1  read request.
- mem_addr  output  ADDR_W  read address; stable while mem_rd=1.
- mem_valid  input  1  read data valid.
- mem_data  input  8  event byte.
- note1  output  6  channel-1 note index (0 = silent).
- note2  output  6  channel-2 note index (0 = silent).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on a natural end without looping.

Behaviour:
- Reset (async, n_reset=0):
  - state=IDLE; mem_rd=0; mem_addr=0; note1=0; note2=0; done=0.
  - Delay counter and prescaler cleared.
  - Reset asserted mid-operation aborts immediately. After release the block waits for start.
- States: IDLE, FETCH, WAIT.
- IDLE:
  - start=1 loads mem_addr=START_ADDR and moves to FETCH.
  - mem_rd=1 in the first following cycle.
- FETCH:
  - mem_rd=1 and mem_addr held.
  - The transfer completes on the rising edge where mem_rd=1 and mem_valid=1; mem_data is decoded on that same edge.
  - mem_valid is ignored while mem_rd=0.
  - No timeout; the block waits indefinitely for mem_valid.
- Decode, applied at the transfer edge:
  - 8'h00-8'h3F: note1 <= data[5:0]; mem_addr+1; stay in FETCH.
  - 8'h40-8'h7F: note2 <= data[5:0]; mem_addr+1; stay in FETCH.
  - 8'h80: zero-length delay, treated as a no-op; mem_addr+1; stay in FETCH.
  - 8'h81-8'hFE: delay n = data-8'h80 ticks; mem_addr+1; go to WAIT. Load the prescaler and delay counter at this edge.
  - 8'hFF, loop_en=1 and mem_addr != START_ADDR: mem_addr <= START_ADDR; stay in FETCH. Notes keep their values.
  - 8'hFF, otherwise (loop_en=0, or an empty melody at START_ADDR): note1=note2=0; done=1 for one cycle; go to IDLE.
- Back-to-back fetches:
  - mem_rd stays high across consecutive transfers.
  - A memory returning mem_valid=1 every cycle gives one event per clk.
- WAIT:
  - mem_rd=0.
  - Lasts exactly n*TICK_DIV clk cycles, counted from the cycle after the decode edge.
  - Then enters FETCH; mem_rd=1 in the next cycle.
  - Delay counter is 7 bits; prescaler width is clog2(TICK_DIV).
- Address arithmetic: mem_addr increments modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0. An end marker is not required for wrap.
- Note outputs:
  - Registered; they change only on decode edges, on stop, or at end of melody.
  - They are unchanged during WAIT.
- stop=1 in any non-IDLE state:
  - Next edge: state=IDLE, mem_rd=0, note1=note2=0, done stays 0.
  - An in-flight read is abandoned, even if mem_valid is high on that same edge.
- Simultaneous and ignored events:
  - start with stop in IDLE: stop wins; the block stays IDLE.
  - start while busy: ignored.
  - stop in IDLE: no effect.

Test Plan:
- Reset then start; memory at 0x10.. = 02,41,FF with 1-cycle valid, loop_en=0:
  - mem_rd high the cycle after start.
  - note1=2, then note2=1.
  - Then note1=note2=0, done pulse, busy falls.
- TICK_DIV=4; stream 05,83,06,FF:
  - note1=5 is held for exactly 12 cycles of mem_rd=0.
  - Then note1=6.
- Memory with 3-cycle valid latency:
  - mem_addr stays stable while mem_rd=1.
  - Each byte is consumed exactly once.
  - Addresses read are 0x10, 0x11, 0x12.
- loop_en=1; stream 07,81,FF:
  - After FF, mem_addr returns to 0x10 and note1=7 is re-asserted; no done pulse.
  - Clear loop_en: the next FF ends playback with done.
- Empty-melody loop guard: FF at 0x10 with loop_en=1 -> a single read, done pulse, IDLE.
- Abort and reset cases:
  - stop during WAIT: notes=0 and IDLE on the next edge; no done pulse.
  - start+stop together in IDLE: stays IDLE.
  - n_reset pulsed mid-FETCH: all outputs return to reset values asynchronously.
- Address wrap: ADDR_W=8, START_ADDR=8'hFE, stream 01,42,03 at FE,FF,00 -> addresses wrap FE, FF, 00 and note1 ends at 3.
